controle_execucao: RTL and testbench
====================================

// Module: controle_execucao
// PURPOSE
//  Run controller for the single-cycle RV32 datapath. Loads program words into
//  instruction memory from a host word stream, then sequences execution via a
//  core clock-enable: run / single-step / host halt, PC breakpoint, ECALL/EBREAK
//  stop and cycle watchdog. Sits between host/debug logic and datapath + imem.
// PARAMETERS
//  ADDR_W     8           imem word-address width (IMEM_WORDS = 2**ADDR_W)
//  CYCLE_W    32          width of executed-cycle counter
//  MAX_CICLOS 32'hFFFFFFFF watchdog limit in executed cycles (0 = disabled)
// PORTS
//  clk             in  1       clock, rising edge
//  reset           in  1       asynchronous, active-low (0 = reset)
//  cmd_valid       in  1       host command valid
//  cmd_op          in  3       0 NOP,1 LOAD,2 RUN,3 STEP,4 HALT,5 SET_BRK,6 CLR_BRK,7 RESET_CORE
//  cmd_arg         in  32      LOAD: word count N; SET_BRK: breakpoint PC
//  cmd_ready       out 1       command accepted when cmd_valid && cmd_ready
//  load_valid      in  1       program word valid
//  load_data       in  32      program word
//  load_ready      out 1       word accepted when load_valid && load_ready
//  pc_atual        in  32      current datapath PC
//  instrucao       in  32      instruction at pc_atual
//  core_en         out 1       datapath PC/regfile/dmem update enable this cycle
//  core_hold_reset out 1       holds datapath reset (PC=0)
//  imem_we         out 1       imem write strobe
//  imem_addr       out ADDR_W  imem word address
//  imem_wdata      out 32      imem write data
//  estado          out 3       0 IDLE,1 LOAD,2 RUN,3 STEP,4 HALTED
//  halt_cause      out 2       0 HOST,1 ECALL/EBREAK,2 BREAKPOINT,3 TIMEOUT
//  ciclos          out CYCLE_W executed-cycle count (cycles with core_en=1)
// BEHAVIOUR
//  Reset (async, reset=0): estado=IDLE, core_en=0, core_hold_reset=1,
//   imem_we=0, imem_addr=0, imem_wdata=0, halt_cause=0, ciclos=0, brk invalid.
//  cmd_ready=1 in IDLE/RUN/HALTED, 0 in LOAD/STEP. load_ready=1 only in LOAD.
//  IDLE: core_hold_reset=1. LOAD->LOAD; RUN->RUN; STEP->STEP; other ops per below.
//  LOAD: N=cmd_arg; N=0 or N>2**ADDR_W -> N=2**ADDR_W. imem_addr starts 0,
//   imem_we=load_valid (comb), imem_wdata=load_data, addr++ per accepted word;
//   after N-th word -> IDLE next cycle, ciclos cleared. Addr never wraps.
//  RUN: core_hold_reset=0. Per cycle, halt check on current pc_atual/instrucao:
//   instrucao==32'h00000073 or 32'h00100073 -> cause 1; brk valid && pc_atual==brk
//   && not first RUN cycle -> cause 2; MAX_CICLOS!=0 && ciclos==MAX_CICLOS -> cause 3.
//   Priority 1>2>3. On hit: core_en=0 same cycle, -> HALTED, halt_cause latched.
//   Else core_en=1 (comb), ciclos++ (saturating). HALT cmd: core_en=0 that
//   cycle, -> HALTED, cause 0; halt check wins over HALT in same cycle.
//   Other ops in RUN accepted and ignored.
//  STEP: one cycle; core_en=1 unless ECALL/EBREAK at pc_atual (cause 1);
//   breakpoint/watchdog ignored; -> HALTED (cause 0 if executed).
//  HALTED: core_hold_reset=0, core_en=0. RUN resumes (breakpoint masked for the
//   first cycle); STEP single-steps; LOAD reloads.
//  SET_BRK stores cmd_arg & ~3, brk valid; CLR_BRK invalidates. Legal in any
//   state with cmd_ready=1, no state change.
//  RESET_CORE: core_hold_reset=1 for 1 cycle, ciclos=0, -> IDLE.
//  NOP: no effect. Reset mid-LOAD/RUN aborts immediately; imem keeps written words.
// TESTING
//  LOAD N=3, words A,B,C with load_valid gaps -> imem writes @0,1,2, then IDLE.
//  LOAD N=0 -> exactly 256 writes @0..255, 256th write then IDLE, no wrap.
//  RUN over addi,addi,ebreak -> core_en high 2 cycles, HALTED, cause 1, ciclos=2.
//  SET_BRK 0x8, RUN -> HALTED at pc=8, cause 2; RUN again -> passes pc 8.
//  MAX_CICLOS=5, infinite loop -> core_en high 5 cycles, HALTED, cause 3.
//  STEP from HALTED -> core_en 1 cycle, ciclos+1; reset=0 mid-RUN -> core_en=0 at once, IDLE.

Source files
------------

// File: rtl/controle_execucao.sv
// rtl/controle_execucao.sv - run controller for the single-cycle RV32 datapath
//
// Loads program words into imem from a host word stream, then gates the core
// clock-enable for run / single-step / host halt, PC breakpoint, ECALL/EBREAK
// stop and a cycle watchdog.
//
// Ports:
//   clk, reset           clock (rising edge), async active-low reset
//   cmd_valid/op/arg     host command; cmd_ready accepts it
//   load_valid/data      program word stream; load_ready accepts a word
//   pc_atual, instrucao  current datapath PC and the instruction at it
//   core_en              datapath state update enable for this cycle
//   core_hold_reset      keeps the datapath in reset (PC=0)
//   imem_we/addr/wdata   instruction memory write port
//   estado, halt_cause   controller state and reason for the last halt
//   ciclos               executed-cycle count (cycles with core_en=1)

module controle_execucao #(
  parameter int unsigned          ADDR_W     = 8,
  parameter int unsigned          CYCLE_W    = 32,
  parameter logic [CYCLE_W-1:0]   MAX_CICLOS = {CYCLE_W{1'b1}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [2:0]         cmd_op,
  input  logic [31:0]        cmd_arg,
  output logic               cmd_ready,
  input  logic               load_valid,
  input  logic [31:0]        load_data,
  output logic               load_ready,
  input  logic [31:0]        pc_atual,
  input  logic [31:0]        instrucao,
  output logic               core_en,
  output logic               core_hold_reset,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [31:0]        imem_wdata,
  output logic [2:0]         estado,
  output logic [1:0]         halt_cause,
  output logic [CYCLE_W-1:0] ciclos
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_STEP   = 3'd3,
    S_HALTED = 3'd4
  } estado_t;

  localparam logic [2:0] OP_LOAD       = 3'd1;
  localparam logic [2:0] OP_RUN        = 3'd2;
  localparam logic [2:0] OP_STEP       = 3'd3;
  localparam logic [2:0] OP_HALT       = 3'd4;
  localparam logic [2:0] OP_SET_BRK    = 3'd5;
  localparam logic [2:0] OP_CLR_BRK    = 3'd6;
  localparam logic [2:0] OP_RESET_CORE = 3'd7;

  localparam logic [1:0] CAUSE_HOST    = 2'd0;
  localparam logic [1:0] CAUSE_SYSTEM  = 2'd1;
  localparam logic [1:0] CAUSE_BRK     = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  localparam logic [31:0]     IMEM_WORDS_32 = 32'd1 << ADDR_W;
  localparam logic [ADDR_W:0] IMEM_WORDS    = IMEM_WORDS_32[ADDR_W:0];

  estado_t              estado_q, estado_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ADDR_W:0]      n_q, n_d;
  logic [31:0]          brk_q, brk_d;
  logic                 brk_valid_q, brk_valid_d;
  logic [1:0]           cause_q, cause_d;
  logic [CYCLE_W-1:0]   ciclos_q, ciclos_d;
  logic                 first_q, first_d;

  logic                 cmd_fire;
  logic                 last_word;
  logic                 is_system;
  logic                 brk_hit;
  logic                 wd_hit;
  logic [ADDR_W:0]      n_clamp;
  logic [CYCLE_W-1:0]   ciclos_inc;

  assign cmd_ready  = (estado_q == S_IDLE) || (estado_q == S_RUN) || (estado_q == S_HALTED);
  assign load_ready = (estado_q == S_LOAD);
  assign cmd_fire   = cmd_valid && cmd_ready;

  // Word count 0 or anything beyond the memory size means "fill the whole imem".
  assign n_clamp = ((cmd_arg == 32'd0) || (cmd_arg > IMEM_WORDS_32)) ? IMEM_WORDS
                                                                    : cmd_arg[ADDR_W:0];

  // addr_q equals the number of words already written, so the final word is at n-1.
  assign last_word = ({1'b0, addr_q} == (n_q - (ADDR_W+1)'(1)));

  assign is_system  = (instrucao == 32'h0000_0073) || (instrucao == 32'h0010_0073);
  // The breakpoint is masked on the first run cycle so a resume from a PC that
  // sits on the breakpoint can make progress.
  assign brk_hit    = brk_valid_q && (pc_atual == brk_q) && !first_q;
  assign wd_hit     = (MAX_CICLOS != '0) && (ciclos_q == MAX_CICLOS);
  assign ciclos_inc = (ciclos_q == {CYCLE_W{1'b1}}) ? ciclos_q : ciclos_q + CYCLE_W'(1);

  assign imem_addr  = addr_q;
  assign estado     = estado_q;
  assign halt_cause = cause_q;
  assign ciclos     = ciclos_q;

  always_comb begin
    estado_d        = estado_q;
    addr_d          = addr_q;
    n_d             = n_q;
    brk_d           = brk_q;
    brk_valid_d     = brk_valid_q;
    cause_d         = cause_q;
    ciclos_d        = ciclos_q;
    first_d         = first_q;
    core_en         = 1'b0;
    core_hold_reset = 1'b0;
    imem_we         = 1'b0;
    imem_wdata      = '0;

    // Breakpoint register commands act in every state that accepts commands.
    if (cmd_fire && (cmd_op == OP_SET_BRK)) begin
      brk_d       = cmd_arg & ~32'd3;
      brk_valid_d = 1'b1;
    end
    if (cmd_fire && (cmd_op == OP_CLR_BRK)) begin
      brk_valid_d = 1'b0;
    end

    case (estado_q)
      S_IDLE, S_HALTED: begin
        core_hold_reset = (estado_q == S_IDLE);
        if (cmd_fire) begin
          case (cmd_op)
            OP_LOAD: begin
              estado_d = S_LOAD;
              addr_d   = '0;
              n_d      = n_clamp;
            end
            OP_RUN: begin
              estado_d = S_RUN;
              first_d  = 1'b1;
            end
            OP_STEP: estado_d = S_STEP;
            OP_RESET_CORE: begin
              estado_d = S_IDLE;
              ciclos_d = '0;
            end
            default: ;
          endcase
        end
      end

      S_LOAD: begin
        imem_we    = load_valid;
        imem_wdata = load_data;
        if (load_valid) begin
          if (last_word) begin
            estado_d = S_IDLE;
            ciclos_d = '0;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end

      S_RUN: begin
        first_d = 1'b0;
        if (is_system) begin
          estado_d = S_HALTED;
          cause_d  = CAUSE_SYSTEM;
        end else if (brk_hit) begin
          estado_d = S_HALTED;
          cause_d  = CAUSE_BRK;
        end else if (wd_hit) begin
          estado_d = S_HALTED;
          cause_d  = CAUSE_TIMEOUT;
        end else if (cmd_fire && (cmd_op == OP_HALT)) begin
          estado_d = S_HALTED;
          cause_d  = CAUSE_HOST;
        end else if (cmd_fire && (cmd_op == OP_RESET_CORE)) begin
          estado_d = S_IDLE;
          ciclos_d = '0;
        end else begin
          core_en  = 1'b1;
          ciclos_d = ciclos_inc;
        end
      end

      S_STEP: begin
        estado_d = S_HALTED;
        if (is_system) begin
          cause_d = CAUSE_SYSTEM;
        end else begin
          core_en  = 1'b1;
          ciclos_d = ciclos_inc;
          cause_d  = CAUSE_HOST;
        end
      end

      default: estado_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q    <= S_IDLE;
      addr_q      <= '0;
      n_q         <= '0;
      brk_q       <= '0;
      brk_valid_q <= 1'b0;
      cause_q     <= CAUSE_HOST;
      ciclos_q    <= '0;
      first_q     <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      addr_q      <= addr_d;
      n_q         <= n_d;
      brk_q       <= brk_d;
      brk_valid_q <= brk_valid_d;
      cause_q     <= cause_d;
      ciclos_q    <= ciclos_d;
      first_q     <= first_d;
    end
  end

endmodule

// File: tb/tb_controle_execucao.sv
// tb/tb_controle_execucao.sv - directed-vector bench for controle_execucao

module tb_controle_execucao;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic        cmd_ready;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic [31:0] pc_atual;
  logic [31:0] instrucao;
  logic        core_en;
  logic        core_hold_reset;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [2:0]  estado;
  logic [1:0]  halt_cause;
  logic [31:0] ciclos;

  localparam logic [31:0] ADDI1  = 32'h0010_0093;
  localparam logic [31:0] ADDI2  = 32'h0020_0113;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] JLOOP  = 32'h0000_006f;

  controle_execucao #(
    .ADDR_W    (8),
    .CYCLE_W   (32),
    .MAX_CICLOS(32'd5)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_op         (cmd_op),
    .cmd_arg        (cmd_arg),
    .cmd_ready      (cmd_ready),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .load_ready     (load_ready),
    .pc_atual       (pc_atual),
    .instrucao      (instrucao),
    .core_en        (core_en),
    .core_hold_reset(core_hold_reset),
    .imem_we        (imem_we),
    .imem_addr      (imem_addr),
    .imem_wdata     (imem_wdata),
    .estado         (estado),
    .halt_cause     (halt_cause),
    .ciclos         (ciclos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Minimal datapath stand-in: imem array, PC advancing by 4 (self-loop on jal x0,0).
  logic [31:0] mem [256];
  logic [31:0] pc_q;
  assign pc_atual  = pc_q;
  assign instrucao = mem[pc_q[9:2]];

  always @(posedge clk) begin
    if (imem_we) mem[imem_addr] <= imem_wdata;
    if (core_hold_reset) pc_q <= 32'd0;
    else if (core_en) pc_q <= (instrucao == JLOOP) ? pc_q : pc_q + 32'd4;
  end

  int wr_count;
  int last_wr_addr;
  int en_count;

  always @(negedge clk) begin
    if (imem_we) begin
      wr_count++;
      last_wr_addr = int'(imem_addr);
    end
    if (core_en) en_count++;
  end

  int passed;
  int total;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [31:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_arg   = 32'd0;
  endtask

  task automatic wait_halt(input string tag);
    int n;
    n = 0;
    while (estado !== 3'd4 && n < 64) begin
      tick();
      n++;
    end
    check({tag, "_halted"}, {29'd0, estado}, 32'd4);
  endtask

  task automatic load_prog(input int n, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] w;
    send_cmd(3'd1, n);
    for (int i = 0; i < n; i++) begin
      case (i)
        0: w = w0;
        1: w = w1;
        2: w = w2;
        default: w = w3;
      endcase
      load_valid = 1'b1;
      load_data  = w;
      tick();
    end
    load_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] words [3];
    int          gaps  [3];
    int          addr_err;

    passed     = 0;
    total      = 0;
    wr_count   = 0;
    en_count   = 0;
    last_wr_addr = 0;
    reset      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = 3'd0;
    cmd_arg    = 32'd0;
    load_valid = 1'b0;
    load_data  = 32'd0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_estado", {29'd0, estado}, 32'd0);
    check("rst_core_en", {31'd0, core_en}, 32'd0);
    check("rst_hold", {31'd0, core_hold_reset}, 32'd1);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", {24'd0, imem_addr}, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_cause", {30'd0, halt_cause}, 32'd0);
    check("rst_ciclos", ciclos, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_load_ready", {31'd0, load_ready}, 32'd0);
    reset = 1'b1;
    tick();

    // LOAD N=0 fills all 256 words, stops at 255 without wrapping
    wr_count = 0;
    addr_err = 0;
    send_cmd(3'd1, 32'd0);
    check("l0_estado", {29'd0, estado}, 32'd1);
    for (int i = 0; i < 256; i++) begin
      load_valid = 1'b1;
      load_data  = NOP;
      if (int'(imem_addr) != i) addr_err++;
      tick();
    end
    load_valid = 1'b0;
    check("l0_addr_seq", addr_err, 32'd0);
    check("l0_idle", {29'd0, estado}, 32'd0);
    tick();
    check("l0_writes", wr_count, 32'd256);
    check("l0_last_addr", last_wr_addr, 32'd255);

    // LOAD N=3 with gaps on load_valid
    words = '{ADDI1, ADDI2, EBREAK};
    gaps  = '{1, 2, 0};
    send_cmd(3'd1, 32'd3);
    check("l3_estado", {29'd0, estado}, 32'd1);
    check("l3_load_ready", {31'd0, load_ready}, 32'd1);
    check("l3_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        load_valid = 1'b0;
        #1;
        check("l3_gap_we", {31'd0, imem_we}, 32'd0);
        tick();
      end
      load_valid = 1'b1;
      load_data  = words[i];
      #1;
      check("l3_we", {31'd0, imem_we}, 32'd1);
      check("l3_addr", {24'd0, imem_addr}, i);
      check("l3_wdata", imem_wdata, words[i]);
      tick();
      load_valid = 1'b0;
    end
    check("l3_idle", {29'd0, estado}, 32'd0);
    check("l3_ciclos", ciclos, 32'd0);

    // RUN addi, addi, ebreak
    en_count = 0;
    send_cmd(3'd2, 32'd0);
    check("run_core_en", {31'd0, core_en}, 32'd1);
    wait_halt("run");
    check("run_en_cycles", en_count, 32'd2);
    check("run_cause", {30'd0, halt_cause}, 32'd1);
    check("run_ciclos", ciclos, 32'd2);

    // Breakpoint at 8 (arg low bits masked), then resume past it
    load_prog(4, NOP, NOP, NOP, EBREAK);
    check("brk_load_ciclos", ciclos, 32'd0);
    send_cmd(3'd5, 32'h0000_000B);
    check("brk_set_estado", {29'd0, estado}, 32'd0);
    en_count = 0;
    send_cmd(3'd2, 32'd0);
    wait_halt("brk");
    check("brk_cause", {30'd0, halt_cause}, 32'd2);
    check("brk_pc", pc_atual, 32'd8);
    check("brk_en_cycles", en_count, 32'd2);
    en_count = 0;
    send_cmd(3'd2, 32'd0);
    wait_halt("brk2");
    check("brk2_cause", {30'd0, halt_cause}, 32'd1);
    check("brk2_ciclos", ciclos, 32'd3);
    check("brk2_en_cycles", en_count, 32'd1);

    // Watchdog with MAX_CICLOS=5 on a self loop
    send_cmd(3'd6, 32'd0);
    load_prog(1, JLOOP, NOP, NOP, NOP);
    en_count = 0;
    send_cmd(3'd2, 32'd0);
    wait_halt("wd");
    check("wd_cause", {30'd0, halt_cause}, 32'd3);
    check("wd_en_cycles", en_count, 32'd5);
    check("wd_ciclos", ciclos, 32'd5);

    // RESET_CORE clears ciclos and returns to IDLE
    send_cmd(3'd7, 32'd0);
    check("rc_estado", {29'd0, estado}, 32'd0);
    check("rc_hold", {31'd0, core_hold_reset}, 32'd1);
    check("rc_ciclos", ciclos, 32'd0);

    // Host HALT during RUN
    en_count = 0;
    send_cmd(3'd2, 32'd0);
    tick();
    tick();
    cmd_valid = 1'b1;
    cmd_op    = 3'd4;
    #1;
    check("halt_core_en", {31'd0, core_en}, 32'd0);
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    check("halt_estado", {29'd0, estado}, 32'd4);
    check("halt_cause", {30'd0, halt_cause}, 32'd0);
    check("halt_ciclos", ciclos, 32'd2);
    check("halt_en_cycles", en_count, 32'd2);

    // STEP from HALTED
    en_count = 0;
    send_cmd(3'd3, 32'd0);
    check("step_estado", {29'd0, estado}, 32'd3);
    check("step_core_en", {31'd0, core_en}, 32'd1);
    tick();
    check("step_halted", {29'd0, estado}, 32'd4);
    check("step_ciclos", ciclos, 32'd3);
    check("step_en_cycles", en_count, 32'd1);

    // Asynchronous reset mid-RUN
    send_cmd(3'd2, 32'd0);
    tick();
    check("ar_running", {31'd0, core_en}, 32'd1);
    reset = 1'b0;
    #1;
    check("ar_core_en", {31'd0, core_en}, 32'd0);
    check("ar_estado", {29'd0, estado}, 32'd0);
    check("ar_ciclos", ciclos, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("ar_hold", {31'd0, core_hold_reset}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
